full_adder_core: RTL and testbench
==================================

Name: full_adder_core

Overview:
- Parameterised ripple-carry full adder: computes a + b + c_in over WIDTH bits and produces sum and carry_out.
- Default configuration (WIDTH=1) is the classic single-bit full adder.
- Result is registered by default, with a one-cycle valid strobe, so the block drops into clocked datapaths.
- With REG_OUT=0 the adder result path is purely combinational, for use inside larger combinational arithmetic.

Parameters:
- WIDTH, 1, operand and sum width in bits (legal range 1..64).
- REG_OUT, 1, 1 = sum/carry_out/out_valid registered (latency 1); 0 = adder result combinational (latency 0).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands on a, b, c_in are valid this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- c_in  input  1  carry into bit 0.
- sum  output  WIDTH  (a + b + c_in) mod 2^WIDTH.
- carry_out  output  1  carry out of bit WIDTH-1.
- out_valid  output  1  sum and carry_out are valid this cycle.

Behaviour:
- Bit cell i:
  - s[i] = a[i] ^ b[i] ^ c[i]
  - c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i])
  - c[0] = c_in; carry_out = c[WIDTH].
- Build the adder as a generate loop of WIDTH identical bit cells in ripple order. No carry-lookahead is required.
- Arithmetic is unsigned. {carry_out, sum} equals a + b + c_in exactly, with no saturation or truncation beyond WIDTH+1 bits.
- REG_OUT=1:
  - On rising clk with rst_n=0: sum <= 0, carry_out <= 0, out_valid <= 0.
  - On rising clk with rst_n=1 and in_valid=1: sum/carry_out <= the combinational result; out_valid <= 1.
  - On rising clk with rst_n=1 and in_valid=0: sum/carry_out hold their previous value; out_valid <= 0.
  - Latency is exactly 1 cycle. Back-to-back in_valid cycles are accepted every cycle with no stall and no backpressure.
  - Reset mid-stream: the operand sampled in the reset cycle is discarded; the first valid output after reset is the operand of the first in_valid cycle with rst_n=1.
  - Simultaneous rst_n=0 and in_valid=1: reset wins.
- REG_OUT=0:
  - sum and carry_out follow a/b/c_in combinationally regardless of rst_n.
  - out_valid = in_valid & rst_n, combinational.
  - No state elements in the result path.
- Reset values of all outputs (REG_OUT=1): sum=0, carry_out=0, out_valid=0.
- X-propagation: no special handling. Outputs are don't-care when out_valid=0.
- Boundary cases, all required:
  - All-ones + all-ones + c_in=1 gives sum = all-ones, carry_out=1.
  - All-zeros + all-zeros + c_in=1 gives sum = 1, carry_out=0.
  - a = all-ones, b = 0, c_in=1 ripples the carry through every bit: sum = 0, carry_out=1.

Test Plan:
- WIDTH=1, REG_OUT=1: drive all 8 combinations of (a,b,c_in) with in_valid=1, one per cycle. One cycle later expect (sum,carry_out), in order:
  - 000->(0,0), 001->(1,0), 010->(1,0), 011->(0,1)
  - 100->(1,0), 101->(0,1), 110->(0,1), 111->(1,1)
  - out_valid=1 each cycle.
- WIDTH=1, REG_OUT=0: same 8 combinations, each held 10 time units. Expect the same results with zero clock latency, and out_valid equal to in_valid while rst_n=1.
- WIDTH=8, REG_OUT=1:
  - a=0xFF, b=0x00, c_in=1 -> sum=0x00, carry_out=1 (full ripple).
  - a=0xFF, b=0xFF, c_in=1 -> sum=0xFF, carry_out=1.
  - a=0x3C, b=0x05, c_in=0 -> sum=0x41, carry_out=0.
- Hold behaviour (REG_OUT=1): after a valid result of 0x41, drop in_valid and change operands for 3 cycles. Expect sum stays 0x41, carry_out stays 0, out_valid=0.
- Reset mid-stream (REG_OUT=1): stream valid operands, then assert rst_n=0 for one cycle with in_valid=1. The next cycle must show sum=0, carry_out=0, out_valid=0. The first post-reset valid operand appears one cycle after it is applied.
- Random: 1000 random (a,b,c_in) with WIDTH=16 and random in_valid gaps. {carry_out,sum} must equal the reference a+b+c_in on every out_valid cycle.

Source files
------------

// File: rtl/full_adder_core.sv
// Parameterised ripple-carry adder: {carry_out, sum} = a + b + c_in.
// Optional output register stage with a one-cycle valid strobe.
module full_adder_core #(
  parameter int unsigned WIDTH   = 1,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             out_valid
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = c_in;

  // Ripple chain of identical full-adder bit cells
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  if (REG_OUT) begin : g_reg
    // Result holds while in_valid is low; valid strobe lasts one cycle
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sum       <= '0;
        carry_out <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) begin
          sum       <= s;
          carry_out <= c[WIDTH];
        end
      end
    end
  end else begin : g_comb
    logic unused_clk;
    assign unused_clk = clk;
    assign sum        = s;
    assign carry_out  = c[WIDTH];
    assign out_valid  = in_valid & rst_n;
  end

endmodule

// File: tb/tb_full_adder_core.sv
// Self-checking bench for full_adder_core: truth tables, boundaries,
// hold, reset mid-stream and randomized 16-bit stream.
module tb_full_adder_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH=1, registered
  logic r1_rst_n, r1_iv, r1_a, r1_b, r1_ci, r1_s, r1_co, r1_ov;
  // WIDTH=1, combinational
  logic c1_rst_n, c1_iv, c1_a, c1_b, c1_ci, c1_s, c1_co, c1_ov;
  // WIDTH=8, registered
  logic       w8_rst_n, w8_iv, w8_ci, w8_co, w8_ov;
  logic [7:0] w8_a, w8_b, w8_s;
  // WIDTH=16, registered
  logic        w16_rst_n, w16_iv, w16_ci, w16_co, w16_ov;
  logic [15:0] w16_a, w16_b, w16_s;

  full_adder_core #(.WIDTH(1), .REG_OUT(1'b1)) u_r1 (
    .clk(clk), .rst_n(r1_rst_n), .in_valid(r1_iv), .a(r1_a), .b(r1_b),
    .c_in(r1_ci), .sum(r1_s), .carry_out(r1_co), .out_valid(r1_ov));

  full_adder_core #(.WIDTH(1), .REG_OUT(1'b0)) u_c1 (
    .clk(clk), .rst_n(c1_rst_n), .in_valid(c1_iv), .a(c1_a), .b(c1_b),
    .c_in(c1_ci), .sum(c1_s), .carry_out(c1_co), .out_valid(c1_ov));

  full_adder_core #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
    .clk(clk), .rst_n(w8_rst_n), .in_valid(w8_iv), .a(w8_a), .b(w8_b),
    .c_in(w8_ci), .sum(w8_s), .carry_out(w8_co), .out_valid(w8_ov));

  full_adder_core #(.WIDTH(16), .REG_OUT(1'b1)) u_w16 (
    .clk(clk), .rst_n(w16_rst_n), .in_valid(w16_iv), .a(w16_a), .b(w16_b),
    .c_in(w16_ci), .sum(w16_s), .carry_out(w16_co), .out_valid(w16_ov));

  typedef struct {
    logic a, b, ci;
    logic s, co;
  } vec1_t;

  typedef struct {
    logic [7:0] a, b;
    logic       ci;
    logic [7:0] s;
    logic       co;
  } vec8_t;

  vec1_t tv1[8];
  vec8_t tv8[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [16:0] model_res;
    logic        model_valid;
    logic [31:0] ref_sum;

    tv1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tv1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tv1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tv1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tv1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tv1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tv1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    tv8[0] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    tv8[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tv8[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    tv8[3] = '{8'h3C, 8'h05, 1'b0, 8'h41, 1'b0};

    // Reset with in_valid asserted: reset must win
    r1_rst_n = 1'b0; r1_iv = 1'b1; r1_a = 1'b1; r1_b = 1'b1; r1_ci = 1'b1;
    c1_rst_n = 1'b1; c1_iv = 1'b0; c1_a = 1'b0; c1_b = 1'b0; c1_ci = 1'b0;
    w8_rst_n = 1'b0; w8_iv = 1'b1; w8_a = 8'hFF; w8_b = 8'hFF; w8_ci = 1'b1;
    w16_rst_n = 1'b0; w16_iv = 1'b1; w16_a = 16'hFFFF; w16_b = 16'h1; w16_ci = 1'b0;
    tick();
    tick();
    chk("r1_reset", {r1_ov, r1_co, r1_s}, 64'h0);
    chk("w8_reset", {w8_ov, w8_co, w8_s}, 64'h0);
    chk("w16_reset", {w16_ov, w16_co, w16_s}, 64'h0);

    // WIDTH=1 registered truth table, back-to-back
    r1_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      r1_iv = 1'b1; r1_a = tv1[i].a; r1_b = tv1[i].b; r1_ci = tv1[i].ci;
      tick();
      chk($sformatf("r1_vec%0d", i), {r1_ov, r1_co, r1_s}, {61'h0, 1'b1, tv1[i].co, tv1[i].s});
    end
    r1_iv = 1'b0;
    tick();
    chk("r1_valid_drop", 64'(r1_ov), 64'h0);

    // WIDTH=1 combinational truth table, zero latency
    for (int i = 0; i < 8; i++) begin
      c1_iv = 1'b1; c1_a = tv1[i].a; c1_b = tv1[i].b; c1_ci = tv1[i].ci;
      #5;
      chk($sformatf("c1_vec%0d", i), {c1_ov, c1_co, c1_s}, {61'h0, 1'b1, tv1[i].co, tv1[i].s});
      #5;
    end
    c1_iv = 1'b0; c1_a = 1'b1; c1_b = 1'b0; c1_ci = 1'b0;
    #5;
    chk("c1_iv_low", {c1_ov, c1_co, c1_s}, 64'b001);
    #5;
    c1_iv = 1'b1; c1_rst_n = 1'b0; c1_a = 1'b1; c1_b = 1'b1; c1_ci = 1'b0;
    #5;
    chk("c1_rst_low", {c1_ov, c1_co, c1_s}, 64'b010);
    #5;

    // WIDTH=8 boundaries; last vector leaves 0x41 for the hold test
    w8_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w8_iv = 1'b1; w8_a = tv8[i].a; w8_b = tv8[i].b; w8_ci = tv8[i].ci;
      tick();
      chk($sformatf("w8_vec%0d", i), {w8_ov, w8_co, w8_s}, {54'h0, 1'b1, tv8[i].co, tv8[i].s});
    end

    // Hold: operands change while in_valid is low
    for (int i = 0; i < 3; i++) begin
      w8_iv = 1'b0; w8_a = 8'(8'hF0 + i); w8_b = 8'hAA; w8_ci = 1'b1;
      tick();
      chk($sformatf("w8_hold%0d", i), {w8_ov, w8_co, w8_s}, {54'h0, 1'b0, 1'b0, 8'h41});
    end

    // Reset mid-stream
    w8_iv = 1'b1; w8_a = 8'h10; w8_b = 8'h01; w8_ci = 1'b0;
    tick();
    w8_a = 8'h80; w8_b = 8'h80; w8_ci = 1'b0;
    tick();
    chk("w8_stream", {w8_ov, w8_co, w8_s}, {54'h0, 1'b1, 1'b1, 8'h00});
    w8_rst_n = 1'b0; w8_a = 8'h77; w8_b = 8'h11; w8_ci = 1'b1;
    tick();
    chk("w8_midreset", {w8_ov, w8_co, w8_s}, 64'h0);
    w8_rst_n = 1'b1; w8_iv = 1'b0; w8_a = 8'hFF; w8_b = 8'hFF;
    tick();
    chk("w8_post_reset_idle", {w8_ov, w8_co, w8_s}, 64'h0);
    w8_iv = 1'b1; w8_a = 8'h10; w8_b = 8'h20; w8_ci = 1'b1;
    tick();
    chk("w8_first_after_reset", {w8_ov, w8_co, w8_s}, {54'h0, 1'b1, 1'b0, 8'h31});

    // Random WIDTH=16 stream against an arithmetic model
    w16_rst_n = 1'b1;
    model_res = 17'h0;
    for (int n = 0; n < 1000; n++) begin
      w16_iv = ($urandom_range(0, 9) < 7);
      w16_a  = 16'($urandom);
      w16_b  = 16'($urandom);
      w16_ci = 1'($urandom);
      model_valid = w16_iv;
      ref_sum = 32'(w16_a) + 32'(w16_b) + 32'(w16_ci);
      if (model_valid) model_res = 17'(ref_sum);
      tick();
      chk("w16_valid", 64'(w16_ov), 64'(model_valid));
      chk("w16_result", 64'({w16_co, w16_s}), 64'(model_res));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
